// File: rtl/data_mem_byte_lane.sv
// Byte-lane data memory for the load/store stage: byte/half/word access, sign/zero-extended loads,
// misalignment faults, 1- or 2-cycle read pipeline and a post-reset zero sweep.
module data_mem_byte_lane #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 1,
  parameter int INIT_ZERO   = 1,
  parameter     MEM_FILE    = "data_mem.hex"
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  we_in,
  input  logic [1:0]            size_in,
  input  logic                  signed_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wd_in,
  output logic                  rsp_valid_out,
  output logic [DATA_WIDTH-1:0] rd_out,
  output logic                  misalign_out,
  output logic                  init_done_out
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int WB    = $clog2(DEPTH_WORDS);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [0:0]            r_state;
  logic [WB-1:0]         r_cnt;
  logic                  r_ready;
  logic                  r_init_done;
  logic                  r_v1;
  logic                  r_m1;
  logic [DATA_WIDTH-1:0] r_d1;

  logic                  w_accept;
  logic                  w_mis;
  logic [WB-1:0]         w_idx;
  logic [LB-1:0]         w_off;
  logic [LANES-1:0]      w_mask;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rword;
  logic [15:0]           w_sel;
  logic [DATA_WIDTH-1:0] w_ext;
  logic [DATA_WIDTH-1:0] w_ldata;
  logic                  w_unused_addr;

  // Upper address bits are dropped, so the array aliases modulo its byte size.
  assign w_idx         = addr_in[LB +: WB];
  assign w_off         = addr_in[LB-1:0];
  assign w_unused_addr = ^addr_in[ADDR_WIDTH-1:LB+WB];
  assign w_accept      = req_valid_in & r_ready;
  assign req_ready_out = r_ready;
  assign init_done_out = r_init_done;

  always_comb begin
    w_mis  = 1'b0;
    w_mask = '0;
    case (size_in)
      2'b00: w_mask = LANES'(1) << w_off;
      2'b01: begin
        w_mis  = w_off[0];
        w_mask = LANES'(3) << w_off;
      end
      2'b10: begin
        w_mis  = (w_off != '0);
        w_mask = '1;
      end
      default: w_mis = 1'b1;
    endcase
  end

  assign w_wdata = wd_in << {w_off, 3'b000};
  assign w_rword = r_mem[w_idx];
  assign w_sel   = 16'(w_rword >> {w_off, 3'b000});

  always_comb begin
    w_ext = w_rword;
    case (size_in)
      2'b00:   w_ext = {{(DATA_WIDTH-8){signed_in & w_sel[7]}}, w_sel[7:0]};
      2'b01:   w_ext = {{(DATA_WIDTH-16){signed_in & w_sel[15]}}, w_sel[15:0]};
      default: w_ext = w_rword;
    endcase
    w_ldata = (we_in || w_mis) ? '0 : w_ext;
  end

  // Sweep counter doubles as the INIT->RUN timer; ready only rises once the array is clean.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_init_done <= (INIT_ZERO == 0);
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state     <= ST_RUN;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          r_ready     <= 1'b1;
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_accept && we_in && !w_mis) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_mask[l]) r_mem[w_idx][l*8 +: 8] <= w_wdata[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_v1 <= 1'b0;
      r_m1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_accept;
      r_m1 <= w_accept & w_mis;
      r_d1 <= w_accept ? w_ldata : '0;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic                  r_v2;
    logic                  r_m2;
    logic [DATA_WIDTH-1:0] r_d2;

    always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
        r_v2 <= 1'b0;
        r_m2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        r_m2 <= r_m1;
        r_d2 <= r_d1;
      end
    end

    assign rsp_valid_out = r_v2;
    assign misalign_out  = r_m2;
    assign rd_out        = r_d2;
  end else begin : g_lat1
    assign rsp_valid_out = r_v1;
    assign misalign_out  = r_m1;
    assign rd_out        = r_d1;
  end

endmodule

// File: tb/tb_data_mem_byte_lane.sv
// Directed bench driving identical traffic into a 1-cycle and a 2-cycle read-latency instance.
module tb_data_mem_byte_lane;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wd;

  logic        ready1, rv1, mis1, done1;
  logic        ready2, rv2, mis2, done2;
  logic [31:0] rd1, rd2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_byte_lane #(.READ_LAT(1)) dut1 (
    .clk_in(clk), .reset_in(rst), .req_valid_in(valid), .req_ready_out(ready1),
    .we_in(we), .size_in(size), .signed_in(sgn), .addr_in(addr), .wd_in(wd),
    .rsp_valid_out(rv1), .rd_out(rd1), .misalign_out(mis1), .init_done_out(done1)
  );

  data_mem_byte_lane #(.READ_LAT(2)) dut2 (
    .clk_in(clk), .reset_in(rst), .req_valid_in(valid), .req_ready_out(ready2),
    .we_in(we), .size_in(size), .signed_in(sgn), .addr_in(addr), .wd_in(wd),
    .rsp_valid_out(rv2), .rd_out(rd2), .misalign_out(mis2), .init_done_out(done2)
  );

  // One isolated request; returns {valid, misalign, data} of each instance at its response cycle.
  task automatic singleReq(input logic w, input logic [1:0] s, input logic sg,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [33:0] r1, output logic [33:0] r2);
    @(negedge clk);
    valid = 1'b1; we = w; size = s; sgn = sg; addr = a; wd = d;
    @(negedge clk);
    valid = 1'b0;
    r1 = {rv1, mis1, rd1};
    @(negedge clk);
    r2 = {rv2, mis2, rd2};
  endtask

  task automatic waitSweep(output int n);
    n = 0;
    while (!(done1 && done2) && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [33:0] r1, r2;
    int n;
    rst = 1'b1; valid = 1'b0; we = 1'b0; size = 2'b00; sgn = 1'b0; addr = '0; wd = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({ready1, rv1, mis1, done1, rd1} !== 36'h0) begin
      bad++; $display("[TB] FAIL reset_state_lat1: got %h want 0", {ready1, rv1, mis1, done1, rd1});
    end
    total++;
    if ({ready2, rv2, mis2, done2, rd2} !== 36'h0) begin
      bad++; $display("[TB] FAIL reset_state_lat2: got %h want 0", {ready2, rv2, mis2, done2, rd2});
    end
    rst = 1'b0;
    waitSweep(n);
    total++;
    if (n !== 256) begin
      bad++; $display("[TB] FAIL sweep_cycles: got %0d want 256", n);
    end
    total++;
    if ({ready1, ready2} !== 2'b11) begin
      bad++; $display("[TB] FAIL ready_after_sweep: got %b want 11", {ready1, ready2});
    end
    singleReq(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_00000000, 34'h2_00000000}) begin
      bad++; $display("[TB] FAIL load_3fc_zero: got %h/%h want %h", r1, r2, 34'h2_00000000);
    end
  endtask

  task automatic test_store_load();
    logic [33:0] r1, r2;
    singleReq(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_00000000, 34'h2_00000000}) begin
      bad++; $display("[TB] FAIL store_word_rsp: got %h/%h want %h", r1, r2, 34'h2_00000000);
    end
    singleReq(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, r1, r2);
    singleReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_1122AA44, 34'h2_1122AA44}) begin
      bad++; $display("[TB] FAIL byte_merge: got %h/%h want %h", r1, r2, 34'h2_1122AA44);
    end
    singleReq(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_FFFFFFAA, 34'h2_FFFFFFAA}) begin
      bad++; $display("[TB] FAIL lb_signed: got %h/%h want %h", r1, r2, 34'h2_FFFFFFAA);
    end
    singleReq(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_00000011, 34'h2_00000011}) begin
      bad++; $display("[TB] FAIL lb_top_lane: got %h/%h want %h", r1, r2, 34'h2_00000011);
    end
  endtask

  task automatic test_half();
    logic [33:0] r1, r2;
    singleReq(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF8001, r1, r2);
    singleReq(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_FFFF8001, 34'h2_FFFF8001}) begin
      bad++; $display("[TB] FAIL lh_signed: got %h/%h want %h", r1, r2, 34'h2_FFFF8001);
    end
    singleReq(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_00008001, 34'h2_00008001}) begin
      bad++; $display("[TB] FAIL lh_unsigned: got %h/%h want %h", r1, r2, 34'h2_00008001);
    end
    singleReq(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_00000080, 34'h2_00000080}) begin
      bad++; $display("[TB] FAIL lbu_msb: got %h/%h want %h", r1, r2, 34'h2_00000080);
    end
    singleReq(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_80010000, 34'h2_80010000}) begin
      bad++; $display("[TB] FAIL half_lane_mask: got %h/%h want %h", r1, r2, 34'h2_80010000);
    end
  endtask

  task automatic test_misalign();
    logic [33:0] r1, r2;
    singleReq(1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFEBABE, r1, r2);
    singleReq(1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, r1, r2);
    total++;
    if ({r1, r2} !== {34'h3_00000000, 34'h3_00000000}) begin
      bad++; $display("[TB] FAIL sw_misaligned: got %h/%h want %h", r1, r2, 34'h3_00000000);
    end
    singleReq(1'b0, 2'b01, 1'b1, 32'h03, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h3_00000000, 34'h3_00000000}) begin
      bad++; $display("[TB] FAIL lh_misaligned: got %h/%h want %h", r1, r2, 34'h3_00000000);
    end
    singleReq(1'b1, 2'b11, 1'b0, 32'h04, 32'hFFFFFFFF, r1, r2);
    total++;
    if ({r1, r2} !== {34'h3_00000000, 34'h3_00000000}) begin
      bad++; $display("[TB] FAIL size11_fault: got %h/%h want %h", r1, r2, 34'h3_00000000);
    end
    singleReq(1'b1, 2'b01, 1'b0, 32'h05, 32'h0000FFFF, r1, r2);
    singleReq(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_CAFEBABE, 34'h2_CAFEBABE}) begin
      bad++; $display("[TB] FAIL fault_no_write: got %h/%h want %h", r1, r2, 34'h2_CAFEBABE);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expD [3];
    logic        ev1, ev2;
    logic [31:0] ed1, ed2;
    expD[0] = 32'h00000000;
    expD[1] = 32'hDEADBEEF;
    expD[2] = 32'h000000BE;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        ev1 = (k <= 3);
        ed1 = ev1 ? expD[k-1] : 32'h0;
        ev2 = (k >= 2 && k <= 4);
        ed2 = ev2 ? expD[k-2] : 32'h0;
        total++;
        if (rv1 !== ev1 || (ev1 && {mis1, rd1} !== {1'b0, ed1})) begin
          bad++; $display("[TB] FAIL b2b_lat1_c%0d: got v=%b m=%b d=%h want v=%b d=%h", k, rv1, mis1, rd1, ev1, ed1);
        end
        total++;
        if (rv2 !== ev2 || (ev2 && {mis2, rd2} !== {1'b0, ed2})) begin
          bad++; $display("[TB] FAIL b2b_lat2_c%0d: got v=%b m=%b d=%h want v=%b d=%h", k, rv2, mis2, rd2, ev2, ed2);
        end
      end
      case (k)
        0: begin valid = 1'b1; we = 1'b1; size = 2'b10; sgn = 1'b0; addr = 32'h40; wd = 32'hDEADBEEF; end
        1: begin valid = 1'b1; we = 1'b0; size = 2'b10; sgn = 1'b1; addr = 32'h40; wd = 32'h0; end
        2: begin valid = 1'b1; we = 1'b0; size = 2'b00; sgn = 1'b0; addr = 32'h41; wd = 32'h0; end
        default: valid = 1'b0;
      endcase
    end
  endtask

  task automatic test_reset_midflight();
    logic [33:0] r1, r2;
    int n;
    int pulses;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rv1 || rv2) pulses++;
      valid = (c >= 40 && c < 60);
      we = 1'b0; size = 2'b10; addr = 32'h0;
    end
    valid = 1'b0;
    total++;
    if ({pulses, done1, ready1} !== {32'd0, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL ignore_during_sweep: got pulses=%0d done=%b ready=%b want 0/0/0", pulses, done1, ready1);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    waitSweep(n);
    total++;
    if (n !== 256) begin
      bad++; $display("[TB] FAIL sweep_restart: got %0d want 256", n);
    end
    singleReq(1'b1, 2'b10, 1'b0, 32'h0, 32'h55AA1234, r1, r2);
    @(negedge clk);
    valid = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0;
    @(posedge clk);
    #1 rst = 1'b1;
    valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rv1 || rv2) pulses++;
      if (c == 1) rst = 1'b0;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("[TB] FAIL inflight_dropped: got %0d pulses want 0", pulses);
    end
    waitSweep(n);
    total++;
    if (n < 250 || n > 256) begin
      bad++; $display("[TB] FAIL sweep_after_flush: got %0d cycles want <=256", n);
    end
    singleReq(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_00000000, 34'h2_00000000}) begin
      bad++; $display("[TB] FAIL swept_word0: got %h/%h want %h", r1, r2, 34'h2_00000000);
    end
    singleReq(1'b1, 2'b10, 1'b0, 32'h400, 32'h0BADF00D, r1, r2);
    singleReq(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, r1, r2);
    total++;
    if ({r1, r2} !== {34'h2_0BADF00D, 34'h2_0BADF00D}) begin
      bad++; $display("[TB] FAIL alias_400: got %h/%h want %h", r1, r2, 34'h2_0BADF00D);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_half();
    test_misalign();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
